// File: rtl/logic_unit_mc.sv
// Multi-cycle bitwise logic unit: operands are processed SLICE bits per cycle, LSB slice first,
// behind valid/ready handshakes on both the request and result sides.
module logic_unit_mc #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_s,
  output logic             o_zero,
  output logic             o_illegal
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LastIdx = CW'(NSLICE - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_a, r_b, r_s;
  logic [2:0]       r_op;
  logic [CW-1:0]    r_idx;
  logic             r_zero, r_illegal;

  logic [SLICE-1:0] w_sl_a, w_sl_b, w_slice;
  logic [WIDTH-1:0] w_s_next;
  logic             w_op_illegal, w_last;

  assign w_op_illegal = (r_op[2:1] == 2'b11);
  assign w_last       = (r_idx == LastIdx);

  // Slice select and write-back use constant offsets so no variable part-selects are needed.
  always_comb begin
    w_sl_a   = '0;
    w_sl_b   = '0;
    w_s_next = r_s;
    for (int k = 0; k < NSLICE; k++) begin
      if (r_idx == CW'(k)) begin
        w_sl_a = r_a[k*SLICE +: SLICE];
        w_sl_b = r_b[k*SLICE +: SLICE];
      end
    end
    case (r_op)
      3'b000:  w_slice = w_sl_a & w_sl_b;
      3'b001:  w_slice = w_sl_a | w_sl_b;
      3'b010:  w_slice = w_sl_a ^ w_sl_b;
      3'b011:  w_slice = w_sl_a & ~w_sl_b;
      3'b100:  w_slice = w_sl_a | ~w_sl_b;
      3'b101:  w_slice = ~(w_sl_a ^ w_sl_b);
      default: w_slice = '0;
    endcase
    for (int k = 0; k < NSLICE; k++) begin
      if (r_idx == CW'(k)) w_s_next[k*SLICE +: SLICE] = w_slice;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_in_valid) w_state_next = StRun;
      StRun:   if (w_last) w_state_next = StDone;
      StDone:  if (i_out_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_s       <= '0;
      r_idx     <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        StIdle: begin
          if (i_in_valid) begin
            r_a       <= i_a;
            r_b       <= i_b;
            r_op      <= i_op;
            r_s       <= '0;
            r_idx     <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
          end
        end
        StRun: begin
          r_s       <= w_s_next;
          r_illegal <= w_op_illegal;
          if (w_last) begin
            // Explicit wrap: NSLICE need not be a power of two.
            r_idx  <= '0;
            r_zero <= (w_s_next == '0);
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_in_ready  = (r_state == StIdle);
  assign o_out_valid = (r_state == StDone);
  assign o_s         = r_s;
  assign o_zero      = r_zero;
  assign o_illegal   = r_illegal;

endmodule

// File: tb/tb_logic_unit_mc.sv
// Self-checking bench for logic_unit_mc: three parameterisations, vector table, scoreboard,
// back-pressure, asynchronous abort and a byte-lane-packed exhaustive OR sweep.
module tb_logic_unit_mc;

  localparam logic [63:0] VA = 64'hF0F0_F0F0_0000_FFFF;
  localparam logic [63:0] VB = 64'hFF00_FF00_FFFF_0000;
  localparam logic [63:0] VXOR = 64'h0FF0_0FF0_FFFF_FFFF;
  localparam logic [63:0] VOR  = 64'hFFF0_FFF0_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  iv, ordy, ir, ov, zf, ilf;
  logic [2:0]  op_in;
  logic [63:0] a_in, b_in;
  logic [63:0] s0, s2;
  logic [31:0] s1;

  always #5 clk = ~clk;

  logic_unit_mc u_d64 (
    .clk(clk), .rst_n(rst_n), .i_in_valid(iv[0]), .o_in_ready(ir[0]), .i_op(op_in),
    .i_a(a_in), .i_b(b_in), .o_out_valid(ov[0]), .i_out_ready(ordy[0]), .o_s(s0),
    .o_zero(zf[0]), .o_illegal(ilf[0])
  );

  logic_unit_mc #(.WIDTH(32), .SLICE(32)) u_d32 (
    .clk(clk), .rst_n(rst_n), .i_in_valid(iv[1]), .o_in_ready(ir[1]), .i_op(op_in),
    .i_a(a_in[31:0]), .i_b(b_in[31:0]), .o_out_valid(ov[1]), .i_out_ready(ordy[1]), .o_s(s1),
    .o_zero(zf[1]), .o_illegal(ilf[1])
  );

  logic_unit_mc #(.WIDTH(64), .SLICE(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .i_in_valid(iv[2]), .o_in_ready(ir[2]), .i_op(op_in),
    .i_a(a_in), .i_b(b_in), .o_out_valid(ov[2]), .i_out_ready(ordy[2]), .o_s(s2),
    .o_zero(zf[2]), .o_illegal(ilf[2])
  );

  typedef struct {int inst; logic [63:0] s; logic z; logic ill;} exp_t;
  typedef struct {logic [2:0] op; logic [63:0] a; logic [63:0] b; logic [63:0] s;
                  logic z; logic ill;} vec_t;

  exp_t sb[$];
  vec_t vt[10];
  int   lat_of[3] = '{4, 1, 8};
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [63:0] get_s(input int i);
    case (i)
      0:       return s0;
      1:       return {32'b0, s1};
      default: return s2;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: a result retires on the edge after a negedge where valid and ready are both high.
  always @(negedge clk) begin : mon
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (ov[i] && ordy[i]) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_result inst %0d: got s=%h expected no result", i, get_s(i));
        end else begin
          e = sb.pop_front();
          chk("result_inst", 64'(i), 64'(e.inst));
          chk("s", get_s(i), e.s);
          chk("zero", {63'b0, zf[i]}, {63'b0, e.z});
          chk("illegal", {63'b0, ilf[i]}, {63'b0, e.ill});
        end
      end
    end
  end

  task automatic do_op(input int inst, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] s_exp, input logic z_exp,
                       input logic ill_exp, input int lat);
    exp_t e;
    int   k;
    k = 0;
    while (!ir[inst] && k < 64) begin
      @(posedge clk); #1;
      k++;
    end
    if (!ir[inst]) begin
      chk("in_ready_timeout", {63'b0, ir[inst]}, 64'd1);
      return;
    end
    op_in = op;
    a_in  = a;
    b_in  = b;
    iv[inst] = 1'b1;
    e.inst = inst;
    e.s    = s_exp;
    e.z    = z_exp;
    e.ill  = ill_exp;
    sb.push_back(e);
    @(posedge clk); #1;
    iv[inst] = 1'b0;
    for (k = 1; k <= 64; k++) begin
      @(posedge clk); #1;
      if (ov[inst]) break;
    end
    chk("latency", 64'(k), 64'(lat));
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [63:0] pa, pb, st;
    logic        zt;

    vt[0] = '{3'b000, VA, VB, 64'hF000_F000_0000_0000, 1'b0, 1'b0};
    vt[1] = '{3'b001, VA, VB, VOR, 1'b0, 1'b0};
    vt[2] = '{3'b010, VA, VB, VXOR, 1'b0, 1'b0};
    vt[3] = '{3'b011, VA, VB, 64'h00F0_00F0_0000_FFFF, 1'b0, 1'b0};
    vt[4] = '{3'b100, VA, VB, 64'hF0FF_F0FF_0000_FFFF, 1'b0, 1'b0};
    vt[5] = '{3'b101, VA, VB, 64'hF00F_F00F_0000_0000, 1'b0, 1'b0};
    vt[6] = '{3'b111, '1, '1, 64'h0, 1'b1, 1'b1};
    vt[7] = '{3'b110, 64'h5, 64'h5, 64'h0, 1'b1, 1'b1};
    vt[8] = '{3'b010, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'h0, 1'b1, 1'b0};
    vt[9] = '{3'b100, 64'h0, '1, 64'h0, 1'b1, 1'b0};

    iv = '0; ordy = 3'b111; op_in = '0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_in_ready", {63'b0, ir[i]}, 64'd1);
      chk("reset_out_valid", {63'b0, ov[i]}, 64'd0);
      chk("reset_s", get_s(i), 64'd0);
      chk("reset_zero", {63'b0, zf[i]}, 64'd0);
      chk("reset_illegal", {63'b0, ilf[i]}, 64'd0);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;

    // All ops on every parameterisation; the 32-bit unit sees only the low half.
    for (int i = 0; i < 3; i++) begin
      for (int v = 0; v < 10; v++) begin
        st = (i == 1) ? (vt[v].s & 64'hFFFF_FFFF) : vt[v].s;
        zt = (i == 1) ? (st == 64'h0) : vt[v].z;
        do_op(i, vt[v].op, vt[v].a, vt[v].b, st, zt, vt[v].ill, lat_of[i]);
      end
    end

    // Back-pressure: result must hold while inputs churn and in_valid pulses are ignored.
    ordy[0] = 1'b0;
    do_op(0, 3'b010, VA, VB, VXOR, 1'b0, 1'b0, 4);
    for (int c = 0; c < 10; c++) begin
      iv[0] = (c % 2 == 0);
      a_in  = {$urandom, $urandom};
      b_in  = {$urandom, $urandom};
      op_in = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
      chk("bp_s", s0, VXOR);
      chk("bp_zero", {63'b0, zf[0]}, 64'd0);
      chk("bp_out_valid", {63'b0, ov[0]}, 64'd1);
      chk("bp_in_ready", {63'b0, ir[0]}, 64'd0);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", {63'b0, ir[0]}, 64'd1);
    chk("bp_release_out_valid", {63'b0, ov[0]}, 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_no_extra_result", {63'b0, ov[0]}, 64'd0);
    end

    // Asynchronous abort two edges after accept; nothing is pushed for this request.
    op_in = 3'b001; a_in = VA; b_in = VB; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_s", s0, 64'd0);
    chk("abort_out_valid", {63'b0, ov[0]}, 64'd0);
    chk("abort_in_ready", {63'b0, ir[0]}, 64'd1);
    chk("abort_zero", {63'b0, zf[0]}, 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      chk("abort_no_out_valid", {63'b0, ov[0]}, 64'd0);
    end
    do_op(0, 3'b001, VA, VB, VOR, 1'b0, 1'b0, 4);

    // Exhaustive 8-bit OR: eight independent (a,b) pairs packed into byte lanes per request.
    for (int a = 0; a < 256; a++) begin
      for (int bh = 0; bh < 32; bh++) begin
        for (int k = 0; k < 8; k++) begin
          pa[k*8 +: 8] = 8'(a);
          pb[k*8 +: 8] = 8'(bh * 8 + k);
        end
        do_op(0, 3'b001, pa, pb, pa | pb, (pa | pb) == 64'h0, 1'b0, 4);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
